// File: rtl/i2c_seq_pkg.sv
// ---------------------------------------------------------------------------
// i2c_seq_pkg
// Shared types for the i2c command sequencer: FSM state encoding, response
// error codes and the command record stored in the command FIFO.
// No ports (package).
// ---------------------------------------------------------------------------
package i2c_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_NACK    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef struct packed {
    logic       rw;
    logic [7:0] data;
  } i2c_cmd_t;

endpackage

// File: rtl/i2c_cmd_fifo.sv
// ---------------------------------------------------------------------------
// i2c_cmd_fifo
// Synchronous FIFO of i2c_cmd_t records. Head is always visible; it is only
// removed by an explicit pop. Full flag is registered so the upstream ready
// depends on occupancy alone.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   push         write push_cmd (ignored when full)
//   push_cmd     command to store
//   pop          remove head (ignored when empty)
//   head         oldest stored command
//   count        occupancy, 0..DEPTH
//   full         occupancy == DEPTH
// ---------------------------------------------------------------------------
module i2c_cmd_fifo
  import i2c_seq_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  i2c_cmd_t      push_cmd,
  input  logic          pop,
  output i2c_cmd_t      head,
  output logic [CW-1:0] count,
  output logic          full
);

  i2c_cmd_t        mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [CW-1:0]   count_next_s;
  logic            full_r;
  logic            push_ok_s;
  logic            pop_ok_s;

  assign push_ok_s = push & ~full_r;
  assign pop_ok_s  = pop & (count_r != {CW{1'b0}});

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_next_s = count_r - {{(CW-1){1'b0}}, 1'b1};
      default: count_next_s = count_r;
    endcase
  end

  // Storage array; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_cmd;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers, occupancy and registered full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CW'(DEPTH));
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = full_r;

endmodule

// File: rtl/i2c_cmd_seq.sv
// ---------------------------------------------------------------------------
// i2c_cmd_seq
// Command sequencer in front of an i2c master. Host commands are queued in
// i2c_cmd_fifo and issued one at a time; NACKed transfers are retried up to
// RETRIES extra times, each attempt is guarded by a TIMEOUT_CYCLES watchdog,
// and one response (read byte + status) is returned per command.
// Ports:
//   i_Clk, i_Rst_n                  clock, asynchronous active-low reset
//   i_Cmd_Valid/o_Cmd_Ready         host command handshake
//   i_Cmd_RW, i_Cmd_Data            command: 0=write/1=read, write byte
//   o_Rsp_Valid/i_Rsp_Ready         response handshake
//   o_Rsp_Data, o_Rsp_Err           read byte, status (00 ok/01 nack/10 timeout)
//   o_Cmd_Count                     FIFO occupancy
//   o_M_Start, o_M_RW, o_M_Data     master control (start pulse, held R/W+byte)
//   i_M_Busy, i_M_Done              master status
//   i_M_Ack_Err, i_M_Data           NACK flag and read byte, valid with done
// ---------------------------------------------------------------------------
module i2c_cmd_seq
  import i2c_seq_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int RETRIES        = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int CW  = $clog2(DEPTH) + 1,
  localparam int RTW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1,
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic          i_Clk,
  input  logic          i_Rst_n,
  input  logic          i_Cmd_Valid,
  output logic          o_Cmd_Ready,
  input  logic          i_Cmd_RW,
  input  logic [7:0]    i_Cmd_Data,
  output logic          o_Rsp_Valid,
  input  logic          i_Rsp_Ready,
  output logic [7:0]    o_Rsp_Data,
  output logic [1:0]    o_Rsp_Err,
  output logic [CW-1:0] o_Cmd_Count,
  output logic          o_M_Start,
  output logic          o_M_RW,
  output logic [7:0]    o_M_Data,
  input  logic          i_M_Busy,
  input  logic          i_M_Done,
  input  logic          i_M_Ack_Err,
  input  logic [7:0]    i_M_Data
);

  state_t          state_r;
  state_t          state_next_s;
  logic [RTW-1:0]  retry_r;
  logic [RTW-1:0]  retry_next_s;
  logic [TW-1:0]   to_cnt_r;
  logic [TW-1:0]   to_next_s;
  logic            pop_s;
  logic            rsp_load_s;
  logic [7:0]      rsp_data_next_s;
  logic [1:0]      rsp_err_next_s;

  logic            start_r;
  logic            m_rw_r;
  logic [7:0]      m_data_r;
  logic            rsp_valid_r;
  logic [7:0]      rsp_data_r;
  logic [1:0]      rsp_err_r;

  i2c_cmd_t        push_cmd_s;
  i2c_cmd_t        head_s;
  logic [CW-1:0]   count_s;
  logic            full_s;

  assign push_cmd_s = '{rw: i_Cmd_RW, data: i_Cmd_Data};

  i2c_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (i_Clk),
    .rst_n    (i_Rst_n),
    .push     (i_Cmd_Valid),
    .push_cmd (push_cmd_s),
    .pop      (pop_s),
    .head     (head_s),
    .count    (count_s),
    .full     (full_s)
  );

  // Next-state, retry/timeout counters and response capture.
  always_comb begin
    state_next_s    = state_r;
    retry_next_s    = retry_r;
    to_next_s       = to_cnt_r;
    pop_s           = 1'b0;
    rsp_load_s      = 1'b0;
    rsp_data_next_s = 8'h00;
    rsp_err_next_s  = ERR_OK;
    case (state_r)
      IDLE: begin
        // The busy gate also covers a master still finishing after a timeout.
        if ((count_s != {CW{1'b0}}) && !i_M_Busy) begin
          state_next_s = ISSUE;
          retry_next_s = '0;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        state_next_s = WAIT;
        to_next_s    = '0;
      end
      WAIT: begin
        // Done is checked first so it wins over a coincident timeout.
        if (i_M_Done) begin
          if (!i_M_Ack_Err) begin
            state_next_s    = RESP;
            rsp_load_s      = 1'b1;
            rsp_data_next_s = head_s.rw ? i_M_Data : 8'h00;
            rsp_err_next_s  = ERR_OK;
          end else if (retry_r < RTW'(RETRIES)) begin
            state_next_s = ISSUE;
            retry_next_s = retry_r + {{(RTW-1){1'b0}}, 1'b1};
          end else begin
            state_next_s    = RESP;
            rsp_load_s      = 1'b1;
            rsp_data_next_s = 8'h00;
            rsp_err_next_s  = ERR_NACK;
          end
        end else if (to_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
          state_next_s    = RESP;
          rsp_load_s      = 1'b1;
          rsp_data_next_s = 8'h00;
          rsp_err_next_s  = ERR_TIMEOUT;
        end else begin
          to_next_s = to_cnt_r + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      RESP: begin
        // Head stays in the FIFO until the host takes the response.
        if (i_Rsp_Ready) begin
          pop_s        = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // FSM state and counters.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_r  <= IDLE;
      retry_r  <= '0;
      to_cnt_r <= '0;
    end else begin
      state_r  <= state_next_s;
      retry_r  <= retry_next_s;
      to_cnt_r <= to_next_s;
    end
  end

  // Master control outputs: start marks the ISSUE cycle, R/W and byte are
  // latched from the head on entry to ISSUE and held through the transfer.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      start_r  <= 1'b0;
      m_rw_r   <= 1'b0;
      m_data_r <= 8'h00;
    end else begin
      start_r <= (state_next_s == ISSUE);
      if (state_next_s == ISSUE) begin
        m_rw_r   <= head_s.rw;
        m_data_r <= head_s.data;
      end else begin
        m_rw_r   <= m_rw_r;
        m_data_r <= m_data_r;
      end
    end
  end

  // Response channel: loaded on entry to RESP, held until accepted.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= 8'h00;
      rsp_err_r   <= ERR_OK;
    end else if (rsp_load_s) begin
      rsp_valid_r <= 1'b1;
      rsp_data_r  <= rsp_data_next_s;
      rsp_err_r   <= rsp_err_next_s;
    end else if ((state_r == RESP) && i_Rsp_Ready) begin
      rsp_valid_r <= 1'b0;
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

  assign o_Cmd_Ready = ~full_s;
  assign o_Cmd_Count = count_s;
  assign o_M_Start   = start_r;
  assign o_M_RW      = m_rw_r;
  assign o_M_Data    = m_data_r;
  assign o_Rsp_Valid = rsp_valid_r;
  assign o_Rsp_Data  = rsp_data_r;
  assign o_Rsp_Err   = rsp_err_r;

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// ---------------------------------------------------------------------------
// tb_i2c_cmd_seq
// Self-checking bench for i2c_cmd_seq with a behavioural i2c master model.
// The master NACKs a configurable number of consecutive attempts, returns a
// configurable read byte, and can hang (never signal done).
// ---------------------------------------------------------------------------
module tb_i2c_cmd_seq;
  import i2c_seq_pkg::*;

  localparam int DEPTH   = 4;
  localparam int RETRIES = 2;
  localparam int TOUT    = 16;
  localparam int CW      = $clog2(DEPTH) + 1;
  localparam int NRAND   = 150;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_rw = 1'b0;
  logic [7:0]    cmd_data = 8'h00;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [7:0]    rsp_data;
  logic [1:0]    rsp_err;
  logic [CW-1:0] cmd_count;
  logic          m_start;
  logic          m_rw;
  logic [7:0]    m_data;

  // master model state
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  logic          m_ack_err = 1'b0;
  logic [7:0]    m_rdata = 8'h00;
  int            lat = 0;
  int            consec = 0;
  int            start_cnt = 0;
  int            hold_viol = 0;
  logic          cap_rw = 1'b0;
  logic [7:0]    cap_data = 8'h00;

  // master model configuration (written only by the stimulus process)
  logic          hang = 1'b0;
  logic          rand_mode = 1'b0;
  int            nack_n = 0;
  logic [7:0]    slave_byte = 8'h00;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_cmd_seq #(
    .DEPTH          (DEPTH),
    .RETRIES        (RETRIES),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .i_Clk       (clk),
    .i_Rst_n     (rst_n),
    .i_Cmd_Valid (cmd_valid),
    .o_Cmd_Ready (cmd_ready),
    .i_Cmd_RW    (cmd_rw),
    .i_Cmd_Data  (cmd_data),
    .o_Rsp_Valid (rsp_valid),
    .i_Rsp_Ready (rsp_ready),
    .o_Rsp_Data  (rsp_data),
    .o_Rsp_Err   (rsp_err),
    .o_Cmd_Count (cmd_count),
    .o_M_Start   (m_start),
    .o_M_RW      (m_rw),
    .o_M_Data    (m_data),
    .i_M_Busy    (m_busy),
    .i_M_Done    (m_done),
    .i_M_Ack_Err (m_ack_err),
    .i_M_Data    (m_rdata)
  );

  // Byte the slave returns in randomized mode, derived from the command byte.
  function automatic logic [7:0] rd_fn(input logic [7:0] d);
    return {d[3:0], d[7:4]} ^ 8'h96;
  endfunction

  // Behavioural master: busy after start, done after a latency, NACKs the
  // first nack_n attempts of a command (in random mode: cmd byte bits [1:0]).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy    <= 1'b0;
      m_done    <= 1'b0;
      m_ack_err <= 1'b0;
      m_rdata   <= 8'h00;
      lat       <= 0;
      consec    <= 0;
    end else begin
      m_done    <= 1'b0;
      m_ack_err <= 1'b0;
      m_rdata   <= 8'h00;
      if (rsp_valid && rsp_ready) consec <= 0;
      if (m_start) begin
        start_cnt <= start_cnt + 1;
        m_busy    <= 1'b1;
        cap_rw    <= m_rw;
        cap_data  <= m_data;
        lat       <= rand_mode ? int'($urandom_range(0, 4)) : 2;
      end else if (m_busy) begin
        if (m_rw !== cap_rw || m_data !== cap_data) hold_viol <= hold_viol + 1;
        if (lat > 0) begin
          lat <= lat - 1;
        end else if (!hang) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          if (consec < (rand_mode ? int'(cap_data[1:0]) : nack_n)) begin
            m_ack_err <= 1'b1;
            consec    <= consec + 1;
          end else begin
            m_rdata <= rand_mode ? rd_fn(cap_data) : slave_byte;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one command from a negedge and return one negedge after it is taken.
  task automatic push_cmd(input logic rw, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_data  = d;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("push_accepted", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for a response, capture it and accept it.
  task automatic wait_rsp(output logic [7:0] d, output logic [1:0] e);
    int n;
    n = 0;
    while (!rsp_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_arrived", 32'(rsp_valid), 32'd1);
    d = rsp_data;
    e = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  typedef struct {
    logic       rw;
    logic [7:0] d;
    int         nack;
    logic [7:0] sb;
    logic [7:0] exp_d;
    logic [1:0] exp_e;
    int         exp_starts;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic [1:0] e;
  } rsp_t;

  initial begin
    vec_t       vt[6];
    rsp_t       q[$];
    rsp_t       r;
    logic [7:0] fd[5];
    logic [7:0] gd;
    logic [1:0] ge;
    int         s0, n, k, got, sent, mcnt, exp_starts, nk;
    logic       pushed5, seen;

    vt[0] = '{1'b0, 8'hA5, 0,  8'h00, 8'h00, ERR_OK,   1};
    vt[1] = '{1'b1, 8'h00, 0,  8'h3C, 8'h3C, ERR_OK,   1};
    vt[2] = '{1'b1, 8'h11, 99, 8'h77, 8'h00, ERR_NACK, 3};
    vt[3] = '{1'b0, 8'h5A, 1,  8'h00, 8'h00, ERR_OK,   2};
    vt[4] = '{1'b1, 8'hE7, 2,  8'hC3, 8'hC3, ERR_OK,   3};
    vt[5] = '{1'b0, 8'hFF, 3,  8'hAA, 8'h00, ERR_NACK, 3};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_count",     32'(cmd_count), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data",  32'(rsp_data),  32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_m_start",   32'(m_start),   32'd0);
    chk("rst_m_rw",      32'(m_rw),      32'd0);
    chk("rst_m_data",    32'(m_data),    32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table-driven single commands
    for (int i = 0; i < 6; i++) begin
      nack_n     = vt[i].nack;
      slave_byte = vt[i].sb;
      s0 = start_cnt;
      push_cmd(vt[i].rw, vt[i].d);
      chk("vec_count_one", 32'(cmd_count), 32'd1);
      wait_rsp(gd, ge);
      chk("vec_rsp_data", 32'(gd), 32'(vt[i].exp_d));
      chk("vec_rsp_err",  32'(ge), 32'(vt[i].exp_e));
      chk("vec_starts",   32'(start_cnt - s0), 32'(vt[i].exp_starts));
      chk("vec_master_byte", 32'(cap_data), 32'(vt[i].d));
      chk("vec_master_rw",   32'(cap_rw),   32'(vt[i].rw));
      chk("vec_count_zero",  32'(cmd_count), 32'd0);
      chk("vec_valid_drop",  32'(rsp_valid), 32'd0);
    end
    nack_n = 0;
    chk("hold_stable_tbl", 32'(hold_viol), 32'd0);

    // Latency: push on edge E, start in the cycle after E+1, one cycle wide;
    // response valid one edge after the edge that raises done.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_data = 8'h42;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("lat_no_start_yet", 32'(m_start), 32'd0);
    chk("lat_count",        32'(cmd_count), 32'd1);
    @(negedge clk);
    chk("lat_start", 32'(m_start), 32'd1);
    @(negedge clk);
    chk("lat_start_width", 32'(m_start), 32'd0);
    n = 0;
    while (!m_done && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("lat_done_seen", 32'(m_done), 32'd1);
    chk("lat_rsp_not_yet", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("lat_rsp_valid", 32'(rsp_valid), 32'd1);
    wait_rsp(gd, ge);
    chk("lat_rsp_err", 32'(ge), 32'(ERR_OK));

    // FIFO full with response stalled, then in-order drain
    rand_mode = 1'b1;
    fd[0] = 8'h10; fd[1] = 8'h24; fd[2] = 8'h38; fd[3] = 8'h4C; fd[4] = 8'h50;
    s0 = start_cnt;
    for (int i = 0; i < 4; i++) push_cmd(1'b1, fd[i]);
    chk("full_ready_low", 32'(cmd_ready), 32'd0);
    chk("full_count",     32'(cmd_count), 32'd4);
    cmd_valid = 1'b1; cmd_data = fd[4];
    repeat (12) @(negedge clk);
    chk("full_still_low", 32'(cmd_ready), 32'd0);
    chk("full_one_issue", 32'(start_cnt - s0), 32'd1);
    chk("full_rsp_wait",  32'(rsp_valid), 32'd1);
    rsp_ready = 1'b1;
    chk("full_no_fallthrough", 32'(cmd_ready), 32'd0);
    got = 0; n = 0; pushed5 = 1'b0;
    while (got < 5 && n < 500) begin
      if (cmd_valid && cmd_ready) pushed5 = 1'b1;
      if (rsp_valid) begin
        chk("drain_data", 32'(rsp_data), 32'(rd_fn(fd[got])));
        chk("drain_err",  32'(rsp_err),  32'(ERR_OK));
        got++;
      end
      @(negedge clk);
      n++;
      if (pushed5) cmd_valid = 1'b0;
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("drain_all", 32'(got), 32'd5);
    chk("drain_count", 32'(cmd_count), 32'd0);
    rand_mode = 1'b0;

    // Timeout, then busy gate and stray done
    hang = 1'b1;
    push_cmd(1'b0, 8'h66);
    n = 0;
    while (!m_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("to_start", 32'(m_start), 32'd1);
    k = 0;
    while (!rsp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("to_wait_cycles", 32'(k), 32'(TOUT + 1));
    wait_rsp(gd, ge);
    chk("to_err",  32'(ge), 32'(ERR_TIMEOUT));
    chk("to_data", 32'(gd), 32'd0);
    s0 = start_cnt;
    push_cmd(1'b0, 8'h77);
    repeat (30) @(negedge clk);
    chk("to_busy_gate",  32'(start_cnt - s0), 32'd0);
    chk("to_busy_count", 32'(cmd_count), 32'd1);
    chk("to_busy_rsp",   32'(rsp_valid), 32'd0);
    hang = 1'b0;
    wait_rsp(gd, ge);
    chk("to_after_err",    32'(ge), 32'(ERR_OK));
    chk("to_after_starts", 32'(start_cnt - s0), 32'd1);
    chk("to_after_count",  32'(cmd_count), 32'd0);

    // Asynchronous reset in the middle of a read
    slave_byte = 8'h99;
    push_cmd(1'b1, 8'h20);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready",     32'(cmd_ready), 32'd1);
    chk("arst_count",     32'(cmd_count), 32'd0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst_m_start",   32'(m_start),   32'd0);
    chk("arst_m_rw",      32'(m_rw),      32'd0);
    chk("arst_m_data",    32'(m_data),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    s0 = start_cnt;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("arst_no_rsp",    32'(seen), 32'd0);
    chk("arst_no_issue",  32'(start_cnt - s0), 32'd0);

    // Randomized traffic against a queue-based reference
    rand_mode = 1'b1;
    s0 = start_cnt;
    sent = 0; got = 0; mcnt = 0; exp_starts = 0;
    for (int cyc = 0; cyc < 20000 && (sent < NRAND || got < sent); cyc++) begin
      @(negedge clk);
      chk("rnd_count", 32'(cmd_count), 32'(mcnt));
      chk("rnd_ready", 32'(cmd_ready), 32'(mcnt < DEPTH));
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("rnd_unexpected_rsp", 32'd1, 32'(q.size()));
        end else begin
          r = q.pop_front();
          chk("rnd_rsp_data", 32'(rsp_data), 32'(r.d));
          chk("rnd_rsp_err",  32'(rsp_err),  32'(r.e));
          got++;
          mcnt--;
        end
      end
      if (sent < NRAND) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_rw    = 1'($urandom_range(0, 1));
        cmd_data  = 8'($urandom_range(0, 255));
        if (cmd_valid && cmd_ready) begin
          nk = int'(cmd_data[1:0]);
          if (nk > RETRIES) begin
            r.d = 8'h00;
            r.e = ERR_NACK;
            exp_starts += RETRIES + 1;
          end else begin
            r.d = cmd_rw ? rd_fn(cmd_data) : 8'h00;
            r.e = ERR_OK;
            exp_starts += nk + 1;
          end
          q.push_back(r);
          sent++;
          mcnt++;
        end
      end else begin
        cmd_valid = 1'b0;
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("rnd_all_sent",   32'(sent), 32'(NRAND));
    chk("rnd_all_got",    32'(got),  32'(NRAND));
    chk("rnd_starts",     32'(start_cnt - s0), 32'(exp_starts));
    chk("rnd_hold",       32'(hold_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
